reg_serial_reader: RTL and testbench
====================================

# reg_serial_reader

Parallel-in/serial-out reader for the register datapath. It captures one WIDTH-bit word from a register bank output on a Start request and shifts it out MSB-first, one bit per wCLK cycle, with a per-bit valid strobe and a one-cycle completion pulse. It sits downstream of the D flip-flop storage registers and unloads their contents serially for debug and transfer. An active-high Hold freezes it, matching the register disable polarity.

## Interface
- WIDTH, 8, data word width; legal range 2..32.
- wCLK  in  1  clock, rising-edge active.
- Reset  in  1  reset, asynchronous, active-high; clock wCLK.
- Hold  in  1  active-high freeze; while 1, all state and outputs hold.
- Start  in  1  capture request, sampled on the rising edge of wCLK.
- DataIn  in  WIDTH  parallel word, sampled only on an accepted Start.
- SerOut  out  1  current serial bit.
- BitValid  out  1  SerOut carries a frame bit.
- Busy  out  1  frame in progress (SHIFT state).
- Done  out  1  one-cycle pulse after the last bit.
- BitCount  out  $clog2(WIDTH+1)  index of the bit on SerOut.

## Operation
- States:
  - IDLE: Busy=0, BitValid=0, SerOut=0, BitCount=0.
  - SHIFT: Busy=1, BitValid=1.
  - DONE: Done=1, Busy=0, BitValid=0, SerOut=0.
- IDLE + Start=1 + Hold=0:
  - Capture DataIn into the shift register and clear BitCount.
  - Go to SHIFT with SerOut=DataIn[WIDTH-1].
- SHIFT, each edge with Hold=0:
  - If BitCount < N-1: shift left, increment BitCount, SerOut = new MSB.
  - If BitCount = N-1: go to DONE.
  - N = WIDTH, or WIDTH+1 with parity (see Configuration).
- Start during SHIFT is ignored. DataIn is not re-sampled.
- DONE + Start=1: capture and go to SHIFT (back-to-back frame, no IDLE cycle).
- DONE + Start=0: go to IDLE.
- Hold=1: no state, shift register, counter or output changes, and Start is ignored. If Hold is raised during DONE, Done stays 1 until the first edge with Hold=0.
- Reset=1, at any time including mid-frame: IDLE immediately, without waiting for a clock edge.
  - Reset values: SerOut=0, BitValid=0, Busy=0, Done=0, BitCount=0, shift register=0.

## Timing
- Define edge 0 as the capture edge (Start=1, Hold=0, in IDLE or DONE).
- Bit k (k=0..N-1) is valid from edge k to edge k+1. Bit 0 = DataIn[WIDTH-1].
- Done is high from edge N to edge N+1.
- Frame length is N cycles of BitValid. Start-to-first-bit latency is 0 cycles after edge 0.
- Each Hold=1 cycle extends the current bit by exactly one cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- PARITY_EN defined:
  - N = WIDTH+1.
  - The final bit (BitCount=WIDTH) is even parity of the captured word (XOR of all bits).
  - BitValid stays 1 for the parity bit.
- PARITY_EN undefined:
  - N = WIDTH.
  - No parity logic or parity register is present.
  - BitCount never exceeds WIDTH-1.

## Test plan
- Basic frame: WIDTH=8, DataIn=8'hA5, Start pulse -> SerOut 1,0,1,0,0,1,0,1 on cycles 0..7 with BitValid=1, BitCount 0..7, then Done=1 for one cycle, then IDLE.
- Parity (PARITY_EN defined):
  - DataIn=8'hA5 -> 9th bit = 0.
  - DataIn=8'h01 -> 9th bit = 1.
  - Done follows the 9th bit.
- Hold mid-frame: DataIn=8'hF0, Hold=1 for 3 cycles while BitCount=3 -> SerOut=1 and BitCount=3 held for 4 cycles total; frame ends 3 cycles late; remaining bits 0,0,0,0.
- Reset mid-frame: Reset asserted during BitCount=4 -> all outputs 0 before the next wCLK edge; after release, Start with DataIn=8'h3C -> clean frame 0,0,1,1,1,1,0,0.
- Start behaviour:
  - Start held high during the frame -> no restart, DataIn changes ignored.
  - Start=1 in DONE with DataIn=8'h81 -> next frame begins directly (Busy low only during the DONE cycle), bits 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/reg_serial_reader.sv
// reg_serial_reader
// Parallel-in / serial-out reader for the register datapath. A word is
// captured on an accepted Start and shifted out MSB-first, one bit per wCLK
// cycle, with BitValid marking frame bits and a one-cycle Done pulse after the
// last bit. Hold freezes every register, including the outputs.
//
// Build option: define PARITY_EN to append an even-parity bit (XOR of the
// captured word) as an extra final frame bit. With PARITY_EN undefined the
// frame is exactly WIDTH bits and no parity logic exists.
module reg_serial_reader #(
    parameter int WIDTH = 8
) (
    input  logic                         wCLK,
    input  logic                         Reset,
    input  logic                         Hold,
    input  logic                         Start,
    input  logic [WIDTH-1:0]             DataIn,
    output logic                         SerOut,
    output logic                         BitValid,
    output logic                         Busy,
    output logic                         Done,
    output logic [$clog2(WIDTH+1)-1:0]   BitCount
);

    localparam int CW = $clog2(WIDTH+1);

`ifdef PARITY_EN
    // Parity bit occupies index WIDTH, so the frame is one bit longer.
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    bitcnt_q;
    logic             serout_q;
    logic             bitvalid_q;
    logic             busy_q;
    logic             done_q;

`ifdef PARITY_EN
    logic             parity_q;

    // Even parity of a captured word: XOR of all its bits.
    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction
`endif

    // Single FSM: state, shift register, counter and all registered outputs.
    always_ff @(posedge wCLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            serout_q   <= 1'b0;
            bitvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (!Hold) begin
            case (state_q)
                // IDLE and DONE both accept a new capture; DONE-to-SHIFT gives
                // back-to-back frames with no idle cycle in between.
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        state_q    <= S_SHIFT;
                        shreg_q    <= DataIn;
                        bitcnt_q   <= '0;
                        serout_q   <= DataIn[WIDTH-1];
                        bitvalid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef PARITY_EN
                        parity_q   <= even_parity(DataIn);
`endif
                    end else begin
                        state_q    <= S_IDLE;
                        bitcnt_q   <= '0;
                        serout_q   <= 1'b0;
                        bitvalid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                    end
                end

                // Start and DataIn are ignored while a frame is in flight.
                S_SHIFT: begin
                    if (bitcnt_q == CW'(LAST_IDX)) begin
                        state_q    <= S_DONE;
                        bitcnt_q   <= '0;
                        serout_q   <= 1'b0;
                        bitvalid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q + CW'(1);
`ifdef PARITY_EN
                        // After the last data bit the parity bit goes out.
                        if (bitcnt_q == CW'(WIDTH-1)) begin
                            serout_q <= parity_q;
                        end else begin
                            serout_q <= shreg_q[WIDTH-2];
                        end
`else
                        serout_q <= shreg_q[WIDTH-2];
`endif
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    bitcnt_q   <= '0;
                    serout_q   <= 1'b0;
                    bitvalid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end else begin
            // Hold: every register keeps its value.
            state_q <= state_q;
        end
    end

    assign SerOut   = serout_q;
    assign BitValid = bitvalid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign BitCount = bitcnt_q;

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed testbench for reg_serial_reader (WIDTH=8). Expected serial
// streams are derived from the hand-chosen words; the parity cases are
// compiled in only when PARITY_EN is defined.
module tb_reg_serial_reader;

    localparam int WIDTH = 8;
`ifdef PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif

    logic       wCLK;
    logic       Reset;
    logic       Hold;
    logic       Start;
    logic [7:0] DataIn;
    logic       SerOut;
    logic       BitValid;
    logic       Busy;
    logic       Done;
    logic [3:0] BitCount;

    int checks_n = 0;
    int fail_n   = 0;

    reg_serial_reader #(.WIDTH(WIDTH)) dut (
        .wCLK     (wCLK),
        .Reset    (Reset),
        .Hold     (Hold),
        .Start    (Start),
        .DataIn   (DataIn),
        .SerOut   (SerOut),
        .BitValid (BitValid),
        .Busy     (Busy),
        .Done     (Done),
        .BitCount (BitCount)
    );

    initial wCLK = 1'b0;
    always #5 wCLK = ~wCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            fail_n++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge wCLK);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_serout"},   32'(SerOut),   32'd0);
        chk({tag, "_bitvalid"}, 32'(BitValid), 32'd0);
        chk({tag, "_busy"},     32'(Busy),     32'd0);
        chk({tag, "_done"},     32'(Done),     32'd0);
        chk({tag, "_bitcount"}, 32'(BitCount), 32'd0);
    endtask

    // Starts at the sample point of bit 0; ends at the Done sample point.
    task automatic run_frame(input string tag, input logic [7:0] w, input bit scramble);
        logic exp_bit;
        for (int k = 0; k < N; k++) begin
            exp_bit = (k < WIDTH) ? w[7-k] : ^w;
            chk($sformatf("%s_bit%0d", tag, k), 32'(SerOut), 32'(exp_bit));
            chk($sformatf("%s_bv%0d", tag, k), 32'(BitValid), 32'd1);
            chk($sformatf("%s_cnt%0d", tag, k), 32'(BitCount), 32'(k));
            chk($sformatf("%s_busy%0d", tag, k), 32'(Busy), 32'd1);
            if (scramble) DataIn = 8'($urandom);
            tick();
        end
        chk({tag, "_done"},    32'(Done),     32'd1);
        chk({tag, "_donebusy"}, 32'(Busy),    32'd0);
        chk({tag, "_donebv"},  32'(BitValid), 32'd0);
        chk({tag, "_doneser"}, 32'(SerOut),   32'd0);
    endtask

    initial begin
        Reset  = 1'b1;
        Hold   = 1'b0;
        Start  = 1'b0;
        DataIn = 8'h00;
        #1;
        chk_idle("reset");
        tick();
        tick();
        Reset = 1'b0;
        tick();
        chk_idle("idle");

        // Start is ignored while Hold is high.
        Hold = 1'b1; Start = 1'b1; DataIn = 8'hFF;
        tick();
        chk_idle("hold_start");
        Hold = 1'b0; Start = 1'b0;

        // Basic frame A5 -> 1,0,1,0,0,1,0,1 then Done, then IDLE.
        DataIn = 8'hA5; Start = 1'b1;
        tick();
        Start = 1'b0;
        run_frame("a5", 8'hA5, 1'b0);
        tick();
        chk_idle("a5_idle");

`ifdef PARITY_EN
        // 8'h01 has odd weight, so its parity bit is 1.
        DataIn = 8'h01; Start = 1'b1;
        tick();
        Start = 1'b0;
        run_frame("p01", 8'h01, 1'b0);
        tick();
        chk_idle("p01_idle");
`endif

        // Hold mid-frame: F0, three held cycles at BitCount=3.
        DataIn = 8'hF0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("f0_bit%0d", k), 32'(SerOut), 32'd1);
            tick();
        end
        chk("f0_bit3", 32'(SerOut), 32'd1);
        chk("f0_cnt3", 32'(BitCount), 32'd3);
        Hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            chk($sformatf("f0_hold_ser%0d", h), 32'(SerOut), 32'd1);
            chk($sformatf("f0_hold_cnt%0d", h), 32'(BitCount), 32'd3);
            chk($sformatf("f0_hold_bv%0d", h), 32'(BitValid), 32'd1);
        end
        Hold = 1'b0;
        tick();
        for (int k = 4; k < WIDTH; k++) begin
            chk($sformatf("f0_bit%0d", k), 32'(SerOut), 32'd0);
            chk($sformatf("f0_cnt%0d", k), 32'(BitCount), 32'(k));
            tick();
        end
`ifdef PARITY_EN
        chk("f0_par", 32'(SerOut), 32'd0);
        tick();
`endif
        chk("f0_done", 32'(Done), 32'd1);
        // Hold during DONE keeps Done high.
        Hold = 1'b1;
        tick();
        chk("f0_done_held", 32'(Done), 32'd1);
        Hold = 1'b0;
        tick();
        chk_idle("f0_idle");

        // Reset mid-frame at BitCount=4, asynchronous.
        DataIn = 8'hFF; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("rst_pre_cnt", 32'(BitCount), 32'd4);
        chk("rst_pre_busy", 32'(Busy), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk_idle("rst_async");
        #1;
        Reset = 1'b0;
        tick();
        chk_idle("rst_after");
        DataIn = 8'h3C; Start = 1'b1;
        tick();
        Start = 1'b0;
        run_frame("3c", 8'h3C, 1'b0);
        tick();
        chk_idle("3c_idle");

        // Start held high, DataIn scrambled during frame; then back-to-back 81.
        DataIn = 8'hC3; Start = 1'b1;
        tick();
        run_frame("c3", 8'hC3, 1'b1);
        DataIn = 8'h81;
        tick();
        Start = 1'b0;
        run_frame("81", 8'h81, 1'b0);
        tick();
        chk_idle("81_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
        $finish;
    end

endmodule
